// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM state codes and stream framing constants for the program loader
package imem_loader_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN0  = 3'd1;
  localparam logic [2:0] S_LEN1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
  localparam int LANE_W  = 8;
  localparam int HDR_LEN = 2;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: packs four stream bytes into a little-endian 32-bit word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [LANE_W-1:0]     din,
  output logic [4*LANE_W-1:0]   word,
  output logic                  last
);
  logic [1:0] lane;
  assign last = en && lane == 2'd3;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lane <= '0;
      word <= '0;
    end else if (en) begin
      word[lane*LANE_W +: LANE_W] <= din;
      lane <= lane + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed program into instruction memory while holding the core in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [31:0]       waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);
  logic [2:0] state, nxt;
  logic [15:0] cnt, hdr;
  logic acc, last, start_ok;
  assign acc = in_valid && in_ready;
  assign start_ok = state == S_IDLE && start;
  assign hdr = {in_data, cnt[7:0]};
  assign core_hold = busy;
  word_assembler u_asm (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (acc && state == S_DATA),
    .din (in_data),
    .word(wdata),
    .last(last)
  );
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE:  nxt = start ? S_LEN0 : S_IDLE;
      S_LEN0:  nxt = acc ? S_LEN1 : S_LEN0;
      S_LEN1:  nxt = !acc ? S_LEN1 : hdr == 16'd0 ? S_DONE :
                     32'(hdr) > (32'd1 << ADDR_W) ? S_ERR : S_DATA;
      S_DATA:  nxt = last ? S_WRITE : S_DATA;
      S_WRITE: nxt = 32'(word_count) + 32'd1 == 32'(cnt) ? S_DONE : S_DATA;
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      we         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      waddr      <= BASE_ADDR;
      word_count <= '0;
      cnt        <= '0;
    end else begin
      state    <= nxt;
      in_ready <= nxt == S_LEN0 || nxt == S_LEN1 || nxt == S_DATA;
      we       <= nxt == S_WRITE;
      busy     <= nxt != S_IDLE;
      done     <= nxt == S_DONE;
      err      <= nxt == S_ERR;
      if (start_ok) begin
        waddr      <= BASE_ADDR;
        word_count <= '0;
      end else if (state == S_WRITE) begin
        waddr      <= waddr + 32'd4;
        word_count <= word_count + 1'b1;
      end
      if (state == S_LEN0 && acc) cnt <= {8'h00, in_data};
      if (state == S_LEN1 && acc) cnt <= hdr;
    end
  end
endmodule
